imem_fetch: RTL and testbench
=============================

// Module: imem_fetch
// PURPOSE
//  Instruction-fetch initiator for the byte-wide instruction memory (8-bit addr/data, we/oe, combinational read).
//  Walks the PC and issues one byte read per cycle, little-endian.
//  Assembles 16-bit (RVC) or 32-bit instructions and hands each one to decode over a valid/ready handshake.
//  Accepts PC redirects from branch/jump resolution.
// PARAMETERS
//  ADDR_W    8      width of the memory byte address and of the PC
//  RESET_PC  8'h00  first fetch address after reset; bit 0 ignored
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  mem_addr     out  ADDR_W  byte address to instruction memory
//  mem_oe       out  1       read enable to memory
//  mem_we       out  1       write enable to memory; constant 0
//  mem_wdata    out  8       write data to memory; constant 0
//  mem_rdata    in   8       read data from memory; valid in the same cycle as mem_addr/mem_oe
//  redirect     in   1       load new PC, abort current fetch
//  redirect_pc  in   ADDR_W  target PC; bit 0 forced to 0
//  instr_valid  out  1       instr/instr_pc/instr_is_rvc valid
//  instr_ready  in   1       decode accepts instruction
//  instr        out  32      instruction; RVC zero-extended to 32 bits
//  instr_pc     out  ADDR_W  address of instr
//  instr_is_rvc out  1       1 = 16-bit instruction
//  fetch_err    out  1       1-cycle pulse: instruction longer than 32 bits (bits[4:2]==3'b111 with [1:0]==2'b11)
// BEHAVIOUR
//  Reset values:
//   mem_addr=RESET_PC, mem_oe=0, instr_valid=0, instr=0, instr_pc=RESET_PC, instr_is_rvc=0, fetch_err=0.
//   pc=RESET_PC, state=B0.
//  FSM states B0, B1, B2, B3, HOLD:
//   B0..B3: mem_oe=1, mem_addr=pc+idx (mod 2^ADDR_W); mem_rdata captured into byte idx at the clock edge.
//   B1 -> HOLD if byte0[1:0]!=2'b11 (RVC); otherwise -> B2.
//   B1 -> B0 with fetch_err pulse if byte0[4:0]==5'b11111; pc unchanged; software must redirect.
//   B2 -> B3 -> HOLD.
//   HOLD: mem_oe=0, mem_addr holds; instr_valid=1; outputs stable until handshake.
//   HOLD & instr_ready -> B0; pc += 2 (RVC) or 4, mod 2^ADDR_W.
//  Latency: RVC valid 2 cycles after B0 entry; 32-bit valid 4 cycles after B0 entry. One instruction in flight, no prefetch.
//  redirect: highest priority in every state.
//   Next state B0, pc=redirect_pc&~1, partial bytes discarded, instr_valid=0 next cycle.
//   If redirect coincides with a HOLD handshake, the handshake completes, then the redirect applies.
//  Wrap: byte addresses and pc wrap modulo 2^ADDR_W, including a 32-bit instruction that straddles 0xFF/0x00.
//  Reset mid-fetch: all registers take reset values immediately; no partial instruction is ever presented.
//  mem_we=0 at all times, so we and oe are never asserted together.
// STRUCTURE
//  Package rv_fetch_pkg:
//   fetch_state_e {B0,B1,B2,B3,HOLD}.
//   Constants RVC_MASK=2'b11, LEN48_PAT=5'b11111.
//   Helper function is_rvc(logic [1:0]).
//  Sub-module instr_len_decode (combinational): byte0 -> {is_rvc, too_long}.
//  Remaining datapath stays in imem_fetch: byte shift register, pc adder, FSM.
// TESTING
//  1. Mem[0..3]=13 05 10 00, ready=1 -> after B0..B3, instr=0x00100513, instr_pc=0, is_rvc=0; next mem_addr=4.
//  2. Mem[4..5]=05 45 -> instr=0x00004505, is_rvc=1, instr_pc=4; 2 read cycles only; next fetch at 6.
//  3. ready=0 for 3 cycles in HOLD -> instr and instr_pc stable, mem_oe=0, mem_addr unchanged; accepted on the 4th cycle.
//  4. redirect=1, redirect_pc=0x21 during B2 -> no valid for the partial instruction; next fetch starts at 0x20.
//  5. pc=0xFE, mem[FE,FF,00,01]=93 00 10 00 -> reads 0xFE,0xFF,0x00,0x01; instr=0x00100093; next pc=0x02.
//  6. byte0=0x1F -> fetch_err pulses once, instr_valid stays 0.
//  7. reset asserted in B3 -> outputs at reset values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package rv_fetch_pkg;

    typedef enum logic [2:0] {B0, B1, B2, B3, HOLD} fetch_state_e;

    localparam logic [1:0] RVC_MASK  = 2'b11;
    localparam logic [4:0] LEN48_PAT = 5'b11111;

    // Any low-bit pattern other than 2'b11 marks a 16-bit compressed instruction.
    function automatic logic is_rvc(input logic [1:0] lsb);
        return (lsb & RVC_MASK) != RVC_MASK;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Classifies an instruction's length from the low bits of its first byte.
module instr_len_decode
    import rv_fetch_pkg::*;
(
    input  logic [4:0] byte0_lo,
    output logic       rvc,
    output logic       too_long
);

    assign rvc      = is_rvc(byte0_lo[1:0]);
    assign too_long = (byte0_lo == LEN48_PAT);

endmodule

// File: rtl/imem_fetch.sv
// Fetches one byte per cycle from a byte-wide memory, assembles 16/32-bit
// instructions little-endian and presents them to decode over valid/ready.
module imem_fetch
    import rv_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_is_rvc,
    output logic              fetch_err
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              is_rvc_q, is_rvc_d;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0] byte_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              dec_rvc, dec_too_long;

    // buf_q[23:16] holds byte0 while in B1, the first byte shifted in.
    instr_len_decode u_len_decode (
        .byte0_lo (buf_q[20:16]),
        .rvc      (dec_rvc),
        .too_long (dec_too_long)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_hold_d = addr_hold_q;
        buf_d       = buf_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        is_rvc_d    = is_rvc_q;
        fetch_err_d = 1'b0;
        byte_idx    = '0;

        unique case (state_q)
            B0: begin
                byte_idx = '0;
                buf_d    = {mem_rdata, buf_q[23:8]};
                state_d  = B1;
            end
            B1: begin
                byte_idx = ADDR_W'(1);
                buf_d    = {mem_rdata, buf_q[23:8]};
                if (dec_too_long) begin
                    fetch_err_d = 1'b1;
                    state_d     = B0;
                end else if (dec_rvc) begin
                    instr_d    = {16'h0000, mem_rdata, buf_q[23:16]};
                    instr_pc_d = pc_q;
                    is_rvc_d   = 1'b1;
                    state_d    = HOLD;
                end else begin
                    state_d = B2;
                end
            end
            B2: begin
                byte_idx = ADDR_W'(2);
                buf_d    = {mem_rdata, buf_q[23:8]};
                state_d  = B3;
            end
            B3: begin
                byte_idx   = ADDR_W'(3);
                instr_d    = {mem_rdata, buf_q};
                instr_pc_d = pc_q;
                is_rvc_d   = 1'b0;
                state_d    = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_q + (is_rvc_q ? ADDR_W'(2) : ADDR_W'(4));
                    state_d = B0;
                end
            end
            default: state_d = B0;
        endcase

        rd_addr = pc_q + byte_idx;
        if (state_q != HOLD) begin
            addr_hold_d = rd_addr;
        end

        // A redirect coinciding with a HOLD handshake still lets decode take
        // the instruction; only the fetch that follows is steered.
        if (redirect) begin
            state_d     = B0;
            pc_d        = redirect_pc & ALIGN_MASK;
            instr_d     = instr_q;
            instr_pc_d  = instr_pc_q;
            is_rvc_d    = is_rvc_q;
            fetch_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= B0;
            pc_q        <= PC_INIT;
            addr_hold_q <= PC_INIT;
            buf_q       <= '0;
            instr_q     <= '0;
            instr_pc_q  <= PC_INIT;
            is_rvc_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_hold_q <= addr_hold_d;
            buf_q       <= buf_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            is_rvc_q    <= is_rvc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Gate read enable with reset so it reads 0 while reset is held.
    assign mem_oe       = reset & (state_q != HOLD);
    assign mem_addr     = (state_q == HOLD) ? addr_hold_q : rd_addr;
    assign mem_we       = 1'b0;
    assign mem_wdata    = 8'h00;
    assign instr_valid  = (state_q == HOLD);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_is_rvc = is_rvc_q;
    assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed scenarios followed by random ready/redirect traffic, all checked
// against a transaction-level model of fetch latency and instruction assembly.
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_is_rvc;
    logic        fetch_err;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    // Model: pc of the instruction being fetched, edges since fetch start,
    // whether decode should see it, and whether an error pulse is due.
    logic [7:0] m_pc;
    int         m_cnt;
    logic       m_valid;
    logic       m_err;
    int         m_len;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    imem_fetch #(
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_oe       (mem_oe),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_is_rvc (instr_is_rvc),
        .fetch_err    (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [7:0] a);
        return mem[a];
    endfunction

    // 0 = over-long (error), otherwise length in bytes.
    function automatic int ilen(input logic [7:0] pc);
        logic [7:0] b0;
        b0 = mem[pc];
        if (b0[4:0] == 5'b11111) return 0;
        if (b0[1:0] != 2'b11) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [7:0] pc, input int len);
        if (len == 2) return {16'h0000, rd(pc + 8'd1), rd(pc)};
        return {rd(pc + 8'd3), rd(pc + 8'd2), rd(pc + 8'd1), rd(pc)};
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0; m_len = 0;
    endtask

    task automatic model_update(input logic rdy, input logic redir, input logic [7:0] rpc);
        int len;
        m_err = 1'b0;
        if (redir) begin
            m_pc = rpc & 8'hFE; m_cnt = 0; m_valid = 1'b0;
        end else if (m_valid) begin
            if (rdy) begin
                m_pc = m_pc + 8'(m_len); m_cnt = 0; m_valid = 1'b0;
            end
        end else begin
            m_cnt++;
            len = ilen(m_pc);
            if (m_cnt == 2 && len == 0) begin
                m_err = 1'b1; m_cnt = 0;
            end else if (m_cnt == len) begin
                m_valid = 1'b1; m_len = len;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] ea;
        check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("err", {31'b0, fetch_err}, {31'b0, m_err});
        check("we", {31'b0, mem_we}, 32'd0);
        check("wdata", {24'b0, mem_wdata}, 32'd0);
        check("oe", {31'b0, mem_oe}, {31'b0, !m_valid});
        if (m_valid) begin
            ea = m_pc + 8'(m_len - 1);
            check("instr", instr, exp_instr(m_pc, m_len));
            check("ipc", {24'b0, instr_pc}, {24'b0, m_pc});
            check("rvc", {31'b0, instr_is_rvc}, {31'b0, m_len == 2});
        end else begin
            ea = m_pc + 8'(m_cnt);
        end
        check("addr", {24'b0, mem_addr}, {24'b0, ea});
    endtask

    // Called at a falling edge: drive inputs, advance the model across the
    // next rising edge, then sample at the following falling edge.
    task automatic step(input logic rdy, input logic redir, input logic [7:0] rpc);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        model_update(rdy, redir, rpc);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_oe"}, {31'b0, mem_oe}, 32'd0);
        check({tag, "_addr"}, {24'b0, mem_addr}, 32'd0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_ipc"}, {24'b0, instr_pc}, 32'd0);
        check({tag, "_rvc"}, {31'b0, instr_is_rvc}, 32'd0);
        check({tag, "_err"}, {31'b0, fetch_err}, 32'd0);
    endtask

    initial begin
        int reads;
        int errs;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]}       = 32'h00100513;
        {mem[5], mem[4]}                       = 16'h4505;
        {mem[9], mem[8], mem[7], mem[6]}       = 32'h00000533;
        {mem[35], mem[34], mem[33], mem[32]}   = 32'h00300113;
        {mem[255], mem[254]}                   = 16'h0093;
        mem[8'h40]                             = 8'h1F;
        {mem[83], mem[82], mem[81], mem[80]}   = 32'h03020113;
        model_reset();

        #12;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;

        // 32-bit instruction at 0
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        check("t1_instr", instr, 32'h00100513);
        check("t1_pc", {24'b0, instr_pc}, 32'h0);
        check("t1_rvc", {31'b0, instr_is_rvc}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        check("t1_next", {24'b0, mem_addr}, 32'h4);

        // compressed instruction at 4: two reads only
        reads = int'(mem_oe);
        step(1'b1, 1'b0, 8'h00);
        reads += int'(mem_oe);
        step(1'b0, 1'b0, 8'h00);
        reads += int'(mem_oe);
        check("t2_reads", reads, 2);
        check("t2_instr", instr, 32'h00004505);
        check("t2_pc", {24'b0, instr_pc}, 32'h4);
        check("t2_rvc", {31'b0, instr_is_rvc}, 32'd1);

        // decode stalls three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            check("t3_instr", instr, 32'h00004505);
            check("t3_oe", {31'b0, mem_oe}, 32'd0);
            check("t3_addr", {24'b0, mem_addr}, 32'h5);
        end
        step(1'b1, 1'b0, 8'h00);
        check("t3_next", {24'b0, mem_addr}, 32'h6);

        // redirect during B2 discards the partial instruction
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h21);
        check("t4_addr", {24'b0, mem_addr}, 32'h20);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        check("t4_pc", {24'b0, instr_pc}, 32'h20);
        step(1'b1, 1'b0, 8'h00);

        // straddle 0xFF/0x00
        mem[0] = 8'h10; mem[1] = 8'h00;
        step(1'b1, 1'b1, 8'hFE);
        check("t5_a0", {24'b0, mem_addr}, 32'hFE);
        step(1'b1, 1'b0, 8'h00);
        check("t5_a1", {24'b0, mem_addr}, 32'hFF);
        step(1'b1, 1'b0, 8'h00);
        check("t5_a2", {24'b0, mem_addr}, 32'h00);
        step(1'b1, 1'b0, 8'h00);
        check("t5_a3", {24'b0, mem_addr}, 32'h01);
        step(1'b1, 1'b0, 8'h00);
        check("t5_instr", instr, 32'h00100093);
        step(1'b1, 1'b0, 8'h00);
        check("t5_next", {24'b0, mem_addr}, 32'h02);

        // over-long instruction
        step(1'b1, 1'b1, 8'h40);
        errs = int'(fetch_err);
        step(1'b1, 1'b0, 8'h00);
        errs += int'(fetch_err);
        step(1'b1, 1'b0, 8'h00);
        errs += int'(fetch_err);
        check("t6_valid", {31'b0, instr_valid}, 32'd0);
        step(1'b1, 1'b1, 8'h50);
        errs += int'(fetch_err);
        check("t6_pulses", errs, 1);

        // reset asserted in B3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        check("t7_b3addr", {24'b0, mem_addr}, 32'h53);
        #2 reset = 1'b0;
        #1 check_reset_vals("t7");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("t7_instr", instr, 32'h00000010);
        check("t7_pc", {24'b0, instr_pc}, 32'h0);
        step(1'b1, 1'b0, 8'h00);

        // random traffic over random memory
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
